// File: rtl/temp_report_sched.sv
// Periodic temperature report scheduler: triggers a measurement, converts the
// 8-bit result to three ASCII digits and streams a 5-byte frame to the UART TX.
module temp_report_sched #(
  parameter int REPORT_CYCLES = 1000000,
  parameter int MEAS_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  output logic       meas_start_o,
  input  logic       meas_done_i,
  input  logic [7:0] meas_data_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic [7:0] overrun_cnt_o
);

  localparam logic [23:0] PERIOD_RELOAD = 24'(REPORT_CYCLES - 1);
  localparam logic [15:0] TMO_LAST      = 16'(MEAS_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_CONV, S_SEND} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [23:0] r_period;
  logic [7:0]  r_ovr;
  logic        r_first;
  logic [15:0] r_tmo;
  logic [7:0]  r_val;
  logic [1:0]  r_hund;
  logic [3:0]  r_tens;
  logic        r_tens_phase;
  logic        r_err;
  logic [2:0]  r_byte_idx;
  logic        w_tick;
  logic [7:0]  w_frame_byte;

  assign w_tick = enable_i && (r_period == 24'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= PERIOD_RELOAD;
    end else if (!enable_i || r_period == 24'd0) begin
      r_period <= PERIOD_RELOAD;
    end else begin
      r_period <= r_period - 24'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr <= 8'd0;
    end else if (w_tick && r_state != S_IDLE && r_ovr != 8'hFF) begin
      r_ovr <= r_ovr + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_tick) w_next_state = S_MEAS;
      S_MEAS: begin
        // Done in the start cycle is ignored; done beats a same-cycle timeout.
        if (!r_first) begin
          if (meas_done_i)            w_next_state = S_CONV;
          else if (r_tmo == TMO_LAST) w_next_state = S_SEND;
        end
      end
      S_CONV: if (r_tens_phase && r_val < 8'd10) w_next_state = S_SEND;
      S_SEND: if (tx_ready_i && r_byte_idx == 3'd4) w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first      <= 1'b0;
      r_tmo        <= 16'd0;
      r_val        <= 8'd0;
      r_hund       <= 2'd0;
      r_tens       <= 4'd0;
      r_tens_phase <= 1'b0;
      r_err        <= 1'b0;
      r_byte_idx   <= 3'd0;
    end else begin
      r_first <= (r_state == S_IDLE) && w_tick;
      unique case (r_state)
        S_IDLE: r_byte_idx <= 3'd0;
        S_MEAS: begin
          if (r_first) begin
            r_tmo <= 16'd0;
          end else if (meas_done_i) begin
            r_val        <= meas_data_i;
            r_hund       <= 2'd0;
            r_tens       <= 4'd0;
            r_tens_phase <= 1'b0;
            r_err        <= 1'b0;
          end else if (r_tmo == TMO_LAST) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        S_CONV: begin
          // One subtraction per cycle; a failed compare ends the phase.
          if (!r_tens_phase) begin
            if (r_val >= 8'd100) begin
              r_val  <= r_val - 8'd100;
              r_hund <= r_hund + 2'd1;
            end else begin
              r_tens_phase <= 1'b1;
            end
          end else if (r_val >= 8'd10) begin
            r_val  <= r_val - 8'd10;
            r_tens <= r_tens + 4'd1;
          end
        end
        S_SEND: if (tx_ready_i) r_byte_idx <= r_byte_idx + 3'd1;
      endcase
    end
  end

  always_comb begin
    w_frame_byte = 8'h0A;
    case (r_byte_idx)
      3'd0:    w_frame_byte = r_err ? 8'h45 : 8'h30 + {6'd0, r_hund};
      3'd1:    w_frame_byte = r_err ? 8'h52 : 8'h30 + {4'd0, r_tens};
      3'd2:    w_frame_byte = r_err ? 8'h52 : 8'h30 + r_val;
      3'd3:    w_frame_byte = 8'h0D;
      default: w_frame_byte = 8'h0A;
    endcase
  end

  assign meas_start_o  = (r_state == S_MEAS) && r_first;
  assign tx_valid_o    = (r_state == S_SEND);
  assign tx_data_o     = (r_state == S_SEND) ? w_frame_byte : 8'd0;
  assign busy_o        = (r_state != S_IDLE);
  assign overrun_cnt_o = r_ovr;

endmodule
